// File: rtl/seq_detect_prog.sv
// seq_detect_prog: programmable byte-pattern detector with overlap and saturating count; define SEQ_DETECT_CASE_FOLD_EN to fold A-Z to a-z in compares
module seq_detect_prog #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 16,
  parameter int LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic             sys_clk,
  input  logic             reset_n,
  input  logic             cfg_load,
  input  logic [7:0]       cfg_byte,
  input  logic             cfg_byte_valid,
  input  logic             cfg_done,
  input  logic [7:0]       data_in,
  input  logic             data_in_valid,
  output logic             check_ok,
  output logic [CNT_W-1:0] match_cnt,
  output logic [LEN_W-1:0] pat_len,
  output logic             busy,
  output logic             cfg_ovf
);
  localparam int IDX_W = $clog2(MAX_LEN);
  localparam logic [LEN_W-1:0] FULL = LEN_W'(MAX_LEN);
  typedef enum logic [1:0] {UNCFG, LOAD, ARMED} state_t;
  state_t state;
  logic [7:0] pat [MAX_LEN];
  logic [7:0] hist [MAX_LEN];
  logic [7:0] nh [MAX_LEN];
  logic [IDX_W-1:0] idx [MAX_LEN];
  logic [LEN_W-1:0] hist_cnt;
  logic match;
  function automatic logic [7:0] fold(input logic [7:0] b);
`ifdef SEQ_DETECT_CASE_FOLD_EN
    return (b >= 8'h41 && b <= 8'h5a) ? (b | 8'h20) : b;
`else
    return b;
`endif
  endfunction
  // compare the history as it looks after taking data_in; nh[0] is newest and pairs with the last pattern byte
  always_comb begin
    nh[0] = data_in;
    for (int j = 1; j < MAX_LEN; j++) nh[j] = hist[j-1];
    match = (pat_len != '0) && (hist_cnt >= pat_len - LEN_W'(1));
    for (int j = 0; j < MAX_LEN; j++) begin
      idx[j] = IDX_W'(pat_len - LEN_W'(j + 1));
      match = match && ((LEN_W'(j) >= pat_len) || (fold(nh[j]) == fold(pat[idx[j]])));
    end
  end
  // control FSM, pattern store, history shift and registered outputs
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ARMED;
      pat_len <= LEN_W'(5);
      hist_cnt <= '0;
      check_ok <= 1'b0;
      match_cnt <= '0;
      busy <= 1'b0;
      cfg_ovf <= 1'b0;
      pat[0] <= 8'h68;
      pat[1] <= 8'h65;
      pat[2] <= 8'h6c;
      pat[3] <= 8'h6c;
      pat[4] <= 8'h6f;
      for (int i = 5; i < MAX_LEN; i++) pat[i] <= 8'h00;
      for (int i = 0; i < MAX_LEN; i++) hist[i] <= 8'h00;
    end else begin
      check_ok <= 1'b0;
      if (cfg_load) begin
        state <= LOAD;
        busy <= 1'b1;
        pat_len <= '0;
        cfg_ovf <= 1'b0;
        match_cnt <= '0;
        hist_cnt <= '0;
        for (int i = 0; i < MAX_LEN; i++) hist[i] <= 8'h00;
      end else begin
        case (state)
          LOAD: begin
            if (cfg_byte_valid && pat_len == FULL) cfg_ovf <= 1'b1;
            if (cfg_byte_valid && pat_len != FULL) begin
              pat[pat_len[IDX_W-1:0]] <= cfg_byte;
              pat_len <= pat_len + LEN_W'(1);
            end
            if (cfg_done) begin
              state <= (pat_len != '0 || cfg_byte_valid) ? ARMED : UNCFG;
              busy <= 1'b0;
            end
          end
          ARMED: if (data_in_valid) begin
            hist[0] <= data_in;
            for (int i = 1; i < MAX_LEN; i++) hist[i] <= hist[i-1];
            hist_cnt <= (hist_cnt == FULL) ? hist_cnt : hist_cnt + LEN_W'(1);
            check_ok <= match;
            if (match && match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_seq_detect_prog.sv
// tb_seq_detect_prog: directed tests for seq_detect_prog (default build and SEQ_DETECT_CASE_FOLD_EN)
module tb_seq_detect_prog;
  logic sys_clk, reset_n, cfg_load, cfg_byte_valid, cfg_done, data_in_valid;
  logic [7:0] cfg_byte, data_in;
  logic check_ok, busy, cfg_ovf, check_ok2, busy2, cfg_ovf2;
  logic [15:0] match_cnt;
  logic [1:0] match_cnt2;
  logic [3:0] pat_len, pat_len2;
  int comparisons = 0, failures = 0, pulses = 0, pulses2 = 0, exp_fold;
  logic [7:0] hits;

  seq_detect_prog dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .cfg_load(cfg_load), .cfg_byte(cfg_byte),
    .cfg_byte_valid(cfg_byte_valid), .cfg_done(cfg_done), .data_in(data_in),
    .data_in_valid(data_in_valid), .check_ok(check_ok), .match_cnt(match_cnt),
    .pat_len(pat_len), .busy(busy), .cfg_ovf(cfg_ovf));

  seq_detect_prog #(.CNT_W(2)) dut2 (
    .sys_clk(sys_clk), .reset_n(reset_n), .cfg_load(cfg_load), .cfg_byte(cfg_byte),
    .cfg_byte_valid(cfg_byte_valid), .cfg_done(cfg_done), .data_in(data_in),
    .data_in_valid(data_in_valid), .check_ok(check_ok2), .match_cnt(match_cnt2),
    .pat_len(pat_len2), .busy(busy2), .cfg_ovf(cfg_ovf2));

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    data_in = b;
    data_in_valid = 1'b1;
    cyc();
    data_in_valid = 1'b0;
    pulses += int'(check_ok);
    pulses2 += int'(check_ok2);
    hits = {hits[6:0], check_ok};
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic load_pat(input string s);
    cfg_load = 1'b1;
    cyc();
    cfg_load = 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      cfg_byte = s[i];
      cfg_byte_valid = 1'b1;
      cyc();
    end
    cfg_byte_valid = 1'b0;
    cfg_done = 1'b1;
    cyc();
    cfg_done = 1'b0;
    pulses = 0;
    pulses2 = 0;
    hits = '0;
  endtask

  task automatic test_reset();
    #12;
    comparisons++; if (check_ok !== 1'b0) begin failures++; $display("FAIL reset_check_ok: got %0d want 0", check_ok); end
    comparisons++; if (match_cnt !== 16'd0) begin failures++; $display("FAIL reset_match_cnt: got %0d want 0", match_cnt); end
    comparisons++; if (pat_len !== 4'd5) begin failures++; $display("FAIL reset_pat_len: got %0d want 5", pat_len); end
    comparisons++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0d want 0", busy); end
    comparisons++; if (cfg_ovf !== 1'b0) begin failures++; $display("FAIL reset_cfg_ovf: got %0d want 0", cfg_ovf); end
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_default_match();
    pulses = 0;
    send_str("hell");
    comparisons++; if (pulses != 0) begin failures++; $display("FAIL default_early: got %0d pulses want 0", pulses); end
    send("o");
    comparisons++; if (check_ok !== 1'b1) begin failures++; $display("FAIL default_check_ok: got %0d want 1", check_ok); end
    comparisons++; if (match_cnt !== 16'd1) begin failures++; $display("FAIL default_match_cnt: got %0d want 1", match_cnt); end
    cyc();
    comparisons++; if (check_ok !== 1'b0) begin failures++; $display("FAIL default_one_cycle: got %0d want 0", check_ok); end
  endtask

  task automatic test_overlap();
    load_pat("aa");
    comparisons++; if (pat_len !== 4'd2) begin failures++; $display("FAIL overlap_pat_len: got %0d want 2", pat_len); end
    send_str("aaaa");
    comparisons++; if (hits[3:0] !== 4'b0111) begin failures++; $display("FAIL overlap_pulses: got %b want 0111", hits[3:0]); end
    comparisons++; if (match_cnt !== 16'd3) begin failures++; $display("FAIL overlap_match_cnt: got %0d want 3", match_cnt); end
    load_pat("hello");
    send_str("hhello");
    comparisons++; if (pulses != 1) begin failures++; $display("FAIL hhello_pulses: got %0d want 1", pulses); end
    comparisons++; if (match_cnt !== 16'd1) begin failures++; $display("FAIL hhello_match_cnt: got %0d want 1", match_cnt); end
  endtask

  task automatic test_gaps();
    load_pat("hello");
    send_str("hel");
    repeat (10) cyc();
    send_str("lo");
    comparisons++; if (pulses != 1) begin failures++; $display("FAIL gap_pulses: got %0d want 1", pulses); end
    comparisons++; if (match_cnt !== 16'd1) begin failures++; $display("FAIL gap_match_cnt: got %0d want 1", match_cnt); end
    load_pat("hello");
    send_str("helxlo");
    comparisons++; if (pulses != 0) begin failures++; $display("FAIL mismatch_pulses: got %0d want 0", pulses); end
    comparisons++; if (match_cnt !== 16'd0) begin failures++; $display("FAIL mismatch_match_cnt: got %0d want 0", match_cnt); end
  endtask

  task automatic test_load_bounds();
    cfg_load = 1'b1;
    cyc();
    cfg_load = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cfg_byte = 8'h30 + 8'(i);
      cfg_byte_valid = 1'b1;
      cyc();
    end
    cfg_byte_valid = 1'b0;
    comparisons++; if (busy !== 1'b1) begin failures++; $display("FAIL load_busy: got %0d want 1", busy); end
    cfg_done = 1'b1;
    cyc();
    cfg_done = 1'b0;
    comparisons++; if (pat_len !== 4'd8) begin failures++; $display("FAIL ovf_pat_len: got %0d want 8", pat_len); end
    comparisons++; if (cfg_ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %0d want 1", cfg_ovf); end
    comparisons++; if (busy !== 1'b0) begin failures++; $display("FAIL done_busy: got %0d want 0", busy); end
    pulses = 0;
    send_str("01234567");
    comparisons++; if (pulses != 1) begin failures++; $display("FAIL full_pat_pulses: got %0d want 1", pulses); end
    load_pat("");
    comparisons++; if (pat_len !== 4'd0) begin failures++; $display("FAIL uncfg_pat_len: got %0d want 0", pat_len); end
    send_str("hellohello");
    comparisons++; if (pulses != 0) begin failures++; $display("FAIL uncfg_pulses: got %0d want 0", pulses); end
    cfg_load = 1'b1;
    cyc();
    cfg_load = 1'b0;
    cfg_byte = "x";
    cfg_byte_valid = 1'b1;
    cyc();
    cfg_byte = "y";
    cfg_done = 1'b1;
    cyc();
    cfg_byte_valid = 1'b0;
    cfg_done = 1'b0;
    comparisons++; if (pat_len !== 4'd2) begin failures++; $display("FAIL byte_done_pat_len: got %0d want 2", pat_len); end
    pulses = 0;
    send_str("xy");
    comparisons++; if (pulses != 1) begin failures++; $display("FAIL byte_done_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_saturation();
    load_pat("z");
    send_str("zzzzz");
    comparisons++; if (pulses2 != 5) begin failures++; $display("FAIL sat_pulses: got %0d want 5", pulses2); end
    comparisons++; if (match_cnt2 !== 2'd3) begin failures++; $display("FAIL sat_match_cnt: got %0d want 3", match_cnt2); end
    comparisons++; if (match_cnt !== 16'd5) begin failures++; $display("FAIL wide_match_cnt: got %0d want 5", match_cnt); end
  endtask

  task automatic test_priority();
    load_pat("hello");
    send_str("hell");
    data_in = "o";
    data_in_valid = 1'b1;
    cfg_load = 1'b1;
    cyc();
    data_in_valid = 1'b0;
    cfg_load = 1'b0;
    comparisons++; if (check_ok !== 1'b0) begin failures++; $display("FAIL prio_check_ok: got %0d want 0", check_ok); end
    comparisons++; if (match_cnt !== 16'd0) begin failures++; $display("FAIL prio_match_cnt: got %0d want 0", match_cnt); end
    comparisons++; if (busy !== 1'b1) begin failures++; $display("FAIL prio_busy: got %0d want 1", busy); end
    load_pat("hello");
    send_str("hello");
    cfg_load = 1'b1;
    comparisons++; if (check_ok !== 1'b1) begin failures++; $display("FAIL inflight_check_ok: got %0d want 1", check_ok); end
    cyc();
    cfg_load = 1'b0;
    comparisons++; if (match_cnt !== 16'd0) begin failures++; $display("FAIL inflight_match_cnt: got %0d want 0", match_cnt); end
  endtask

  task automatic test_async_reset();
    cfg_load = 1'b1;
    cyc();
    cfg_load = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cfg_byte = 8'h41 + 8'(i);
      cfg_byte_valid = 1'b1;
      cyc();
    end
    cfg_byte_valid = 1'b0;
    comparisons++; if (cfg_ovf !== 1'b1) begin failures++; $display("FAIL pre_reset_ovf: got %0d want 1", cfg_ovf); end
    #2 reset_n = 1'b0;
    #1;
    comparisons++; if (busy !== 1'b0) begin failures++; $display("FAIL async_busy: got %0d want 0", busy); end
    comparisons++; if (cfg_ovf !== 1'b0) begin failures++; $display("FAIL async_ovf: got %0d want 0", cfg_ovf); end
    comparisons++; if (pat_len !== 4'd5) begin failures++; $display("FAIL async_pat_len: got %0d want 5", pat_len); end
    #1 reset_n = 1'b1;
    cyc();
    pulses = 0;
    send_str("hello");
    comparisons++; if (pulses != 1) begin failures++; $display("FAIL post_reset_pulses: got %0d want 1", pulses); end
    comparisons++; if (match_cnt !== 16'd1) begin failures++; $display("FAIL post_reset_match_cnt: got %0d want 1", match_cnt); end
    pulses = 0;
    send_str("HELLO");
    comparisons++; if (pulses != exp_fold) begin failures++; $display("FAIL fold_pulses: got %0d want %0d", pulses, exp_fold); end
    comparisons++; if (match_cnt !== 16'(1 + exp_fold)) begin failures++; $display("FAIL fold_match_cnt: got %0d want %0d", match_cnt, 1 + exp_fold); end
  endtask

  initial begin
`ifdef SEQ_DETECT_CASE_FOLD_EN
    exp_fold = 1;
`else
    exp_fold = 0;
`endif
    reset_n = 1'b0;
    cfg_load = 1'b0;
    cfg_byte = 8'h00;
    cfg_byte_valid = 1'b0;
    cfg_done = 1'b0;
    data_in = 8'h00;
    data_in_valid = 1'b0;
    hits = '0;
    test_reset();
    test_default_match();
    test_overlap();
    test_gaps();
    test_load_bounds();
    test_saturation();
    test_priority();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparisons, failures);
    $finish;
  end
endmodule

// File: doc/seq_detect_prog.md
Name: seq_detect_prog

Overview:
- Parametrised successor to the fixed "hello" byte-sequence checker.
- Detects a runtime-programmable byte pattern of 1..MAX_LEN bytes in a qualified byte stream.
- Detects overlapping occurrences correctly and keeps a saturating match counter.
- Sits between the UART/byte receive path and control logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bytes (legal range 5..32).
CNT_W, 16, width of match_cnt.
LEN_W, $clog2(MAX_LEN+1), width of pat_len (derived; do not override).

Ports:
sys_clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
cfg_load  in  1  pulse: clear pattern and enter LOAD
cfg_byte  in  8  pattern byte
cfg_byte_valid  in  1  cfg_byte qualifier
cfg_done  in  1  pulse: end pattern load
data_in  in  8  stream byte
data_in_valid  in  1  data_in qualifier
check_ok  out  1  one-cycle match pulse
match_cnt  out  CNT_W  saturating count of matches
pat_len  out  LEN_W  current pattern length
busy  out  1  high while in LOAD
cfg_ovf  out  1  sticky: pattern bytes dropped during the last load

Behaviour:
- Clock and reset: one clock (sys_clk); reset is asynchronous and active-low (reset_n).
- Reset values:
  - State ARMED with the default pattern "hello" (pat_len=5).
  - History empty; check_ok=0, match_cnt=0, busy=0, cfg_ovf=0.
- State machine:
  - UNCFG: no pattern, pat_len=0, matching disabled. cfg_load -> LOAD.
  - LOAD: busy=1; data_in is ignored.
    - cfg_byte_valid writes the byte at index pat_len and increments pat_len.
    - If pat_len==MAX_LEN, the byte is dropped and cfg_ovf is set.
    - cfg_done -> ARMED if pat_len>=1, else -> UNCFG.
    - cfg_byte_valid and cfg_done in the same cycle: the byte is stored first, then the done transition is taken.
    - cfg_load while in LOAD restarts the load.
  - ARMED: matching active. cfg_load -> LOAD.
- Entering LOAD (any cfg_load): pat_len=0, cfg_ovf=0, match_cnt=0, history cleared, hist_cnt=0.
- Matching (ARMED, data_in_valid=1):
  - The byte shifts into a MAX_LEN-deep history; hist_cnt increments and saturates at MAX_LEN.
  - Match condition: hist_cnt (including the new byte) >= pat_len, and the newest pat_len history bytes equal pattern[0..pat_len-1] in order.
  - Overlap is allowed: the history is not flushed on a match.
- Latency:
  - check_ok is registered and high for exactly the one cycle after the completing byte's valid cycle.
  - match_cnt updates on the same edge that raises check_ok.
  - Back-to-back matches give a check_ok high on consecutive cycles.
- data_in_valid=0: history, check_ok (forced 0) and counters hold; idle gaps of any length between pattern bytes are allowed.
- match_cnt saturates at 2^CNT_W-1; check_ok still pulses at saturation.
- Simultaneous events:
  - cfg_load and data_in_valid in the same cycle: cfg_load wins and the byte is dropped.
  - A check_ok already in flight still pulses; match_cnt is then cleared.
- Reset mid-load or mid-match: immediate return to the reset values, including the default pattern.
- Unused pattern slots above pat_len are don't-care and must not affect matching.

Optional Feature:
- Macro: SEQ_DETECT_CASE_FOLD_EN.
- Defined: bytes 0x41-0x5A are folded to 0x61-0x7A before compare, for both stored pattern bytes and data_in. "HeLLo" matches pattern "hello". Stored and reported values are unchanged apart from the fold used in the compare.
- Undefined: exact 8-bit compare, no folding logic synthesised.

Test Plan:
- Reset default: after reset, stream "h","e","l","l","o" with valid every cycle -> check_ok=1 one cycle after the "o" cycle; match_cnt=1; pat_len=5.
- Overlap: load pattern "aa" (cfg_load, 2 bytes, cfg_done), stream "aaaa" -> 3 check_ok pulses on consecutive cycles; match_cnt=3. The stream "hhello" under the default pattern -> 1 match.
- Gaps and mismatch, default pattern:
  - "hel", 10 idle cycles, "lo" -> 1 match.
  - "helxlo" -> no match, match_cnt=0.
- Load boundaries:
  - MAX_LEN=8, write 10 bytes -> pat_len=8, cfg_ovf=1.
  - cfg_load then immediate cfg_done -> UNCFG, stream of any bytes gives check_ok=0.
  - Byte and cfg_done in the same cycle -> pat_len counts that byte.
- Saturation and priority:
  - CNT_W=2, 5 matches -> match_cnt stays 3, 5 pulses seen.
  - cfg_load coincident with a completing byte -> that byte ignored, match_cnt=0, busy=1 next cycle.
- Async reset mid-LOAD (reset_n low between clock edges) -> outputs reach reset values before the next edge; "hello" then matches. With SEQ_DETECT_CASE_FOLD_EN defined, "HELLO" also matches.
